// File: rtl/msx_mouse_pkg.sv
// Shared types, defaults and the saturation helper for the MSX mouse port.
package msx_mouse_pkg;

    // Nibble sequencer position: X high, X low, Y high, Y low.
    typedef enum logic [1:0] {
        XH = 2'd0,
        XL = 2'd1,
        YH = 2'd2,
        YL = 2'd3
    } nib_state_t;

    // Idle clk_sys cycles (no stra toggle) before the sequencer resyncs to XH.
    localparam int TIMEOUT_CYCLES_DEF = 100000;

    // Clamp a 10-bit signed intermediate to the 8-bit signed range.
    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'sd127;
        else if (v < -10'sd128)
            return -8'sd128;
        else
            return $signed(v[7:0]);
    endfunction

endpackage

// File: rtl/msx_mouse_acc.sv
// Saturating 8-bit motion accumulator with snapshot-and-clear.
// A snapshot copies the current total into lat and restarts the total from
// zero; a delta arriving in the same cycle lands on the fresh total.
module msx_mouse_acc
    import msx_mouse_pkg::*;
#(
    parameter bit NEGATE = 1'b0   // 1: subtract the delta instead of adding
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       add,
    input  logic       snap,
    input  logic [8:0] delta,
    output logic [7:0] acc,
    output logic [7:0] lat
);

    logic signed [9:0] d_ext;
    logic signed [9:0] base;
    logic signed [9:0] sum;

    // Widen to 10 bits so -256 can be negated and sums cannot wrap.
    always_comb begin
        d_ext = {delta[8], delta};
        base  = snap ? 10'sd0 : {acc[7], acc[7], acc};
        sum   = NEGATE ? (base - d_ext) : (base + d_ext);
    end

    // Running total and snapshot latch.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            acc <= '0;
            lat <= '0;
        end else begin
            if (snap)
                lat <= acc;
            if (add)
                acc <= sat8(sum);
            else if (snap)
                acc <= '0;
        end
    end

endmodule

// File: rtl/msx_mouse_port.sv
// PS/2 mouse reports -> MSX port-A mouse nibble protocol.
// Each stra toggle shifts out the next nibble (XH, XL, YH, YL); reading XH
// snapshots both axes. Port A belongs to the mouse from its last report
// until any joystick activity.
module msx_mouse_port
    import msx_mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_W           = 18
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [8:0] mouse_x,
    input  logic [8:0] mouse_y,
    input  logic [7:0] mouse_flags,
    input  logic       mouse_strobe,
    input  logic       joy_active,
    input  logic       stra,
    output logic       mouse_en,
    output logic [5:0] port_out
);

    logic            stra_d;
    logic            tog;
    logic            en_nxt;
    logic            snap;
    nib_state_t      state, state_nxt;
    logic [TO_W-1:0] timeout, timeout_nxt;
    logic [5:0]      port_nxt;
    logic [7:0]      acc_x, acc_y, lat_x, lat_y;

    // X is inverted: PS/2 right-positive vs MSX left-positive.
    msx_mouse_acc #(.NEGATE(1'b1)) u_acc_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .add     (mouse_strobe),
        .snap    (snap),
        .delta   (mouse_x),
        .acc     (acc_x),
        .lat     (lat_x)
    );

    msx_mouse_acc #(.NEGATE(1'b0)) u_acc_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .add     (mouse_strobe),
        .snap    (snap),
        .delta   (mouse_y),
        .acc     (acc_y),
        .lat     (lat_y)
    );

    // Sequencer, timeout and port output next-state logic.
    // The enable value taking effect this edge (en_nxt) gates everything,
    // so port_out drops to idle in the same cycle mouse_en clears.
    always_comb begin
        en_nxt      = mouse_strobe | (mouse_en & ~joy_active);
        tog         = stra ^ stra_d;
        snap        = en_nxt & tog & (state == XH);
        state_nxt   = state;
        timeout_nxt = timeout;
        port_nxt    = port_out;
        if (!en_nxt) begin
            state_nxt   = XH;
            timeout_nxt = '0;
            port_nxt    = 6'h3F;
        end else begin
            port_nxt[5:4] = ~mouse_flags[1:0];
            if (tog) begin
                timeout_nxt = TO_W'(TIMEOUT_CYCLES);
                case (state)
                    XH: begin port_nxt[3:0] = acc_x[7:4]; state_nxt = XL; end
                    XL: begin port_nxt[3:0] = lat_x[3:0]; state_nxt = YH; end
                    YH: begin port_nxt[3:0] = lat_y[7:4]; state_nxt = YL; end
                    default: begin port_nxt[3:0] = lat_y[3:0]; state_nxt = XH; end
                endcase
            end else if (timeout != '0) begin
                timeout_nxt = timeout - TO_W'(1);
                if (timeout == TO_W'(1))
                    state_nxt = XH;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mouse_en <= 1'b0;
            stra_d   <= 1'b0;
            state    <= XH;
            timeout  <= '0;
            port_out <= 6'h3F;
        end else begin
            mouse_en <= en_nxt;
            stra_d   <= stra;
            state    <= state_nxt;
            timeout  <= timeout_nxt;
            port_out <= port_nxt;
        end
    end

endmodule

// File: tb/tb_msx_mouse_port.sv
// Bench for msx_mouse_port: directed scenarios with literal expectations,
// then randomized traffic, all shadowed by a read-position model.
module tb_msx_mouse_port;

    localparam int TO = 200;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] mouse_x = '0;
    logic [8:0] mouse_y = '0;
    logic [7:0] mouse_flags = '0;
    logic       mouse_strobe = 1'b0;
    logic       joy_active = 1'b0;
    logic       stra = 1'b0;
    logic       mouse_en;
    logic [5:0] port_out;

    int n_checks = 0;
    int n_errors = 0;

    msx_mouse_port #(.TIMEOUT_CYCLES(TO), .TO_W(18)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .mouse_flags  (mouse_flags),
        .mouse_strobe (mouse_strobe),
        .joy_active   (joy_active),
        .stra         (stra),
        .mouse_en     (mouse_en),
        .port_out     (port_out)
    );

    // Clock.
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Totals as plain integers, a read position 0..3 and a countdown.
    int         m_ax = 0, m_ay = 0, m_lx = 0, m_ly = 0;
    int         m_pos = 0, m_to = 0;
    bit         m_en = 1'b0;
    logic       m_stra = 1'b0;
    logic [5:0] m_port = 6'h3F;

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    always @(posedge clk_sys or posedge reset) begin
        int  bx, by, sx, sy;
        bit  tg, en;
        if (reset) begin
            m_ax = 0; m_ay = 0; m_lx = 0; m_ly = 0;
            m_pos = 0; m_to = 0; m_en = 1'b0; m_stra = 1'b0; m_port = 6'h3F;
        end else begin
            tg = (stra != m_stra);
            m_stra = stra;
            en = mouse_strobe ? 1'b1 : (joy_active ? 1'b0 : m_en);
            bx = m_ax;
            by = m_ay;
            if (en) begin
                m_port[5:4] = ~mouse_flags[1:0];
                if (tg) begin
                    case (m_pos)
                        0: begin m_port[3:0] = m_ax[7:4]; m_lx = m_ax; m_ly = m_ay; bx = 0; by = 0; end
                        1: m_port[3:0] = m_lx[3:0];
                        2: m_port[3:0] = m_ly[7:4];
                        default: m_port[3:0] = m_ly[3:0];
                    endcase
                    m_pos = (m_pos + 1) % 4;
                    m_to = TO;
                end else if (m_to > 0) begin
                    m_to--;
                    if (m_to == 0) m_pos = 0;
                end
            end else begin
                m_port = 6'h3F;
                m_pos = 0;
                m_to = 0;
            end
            if (mouse_strobe) begin
                sx = int'($signed(mouse_x));
                sy = int'($signed(mouse_y));
                bx = clamp8(bx - sx);
                by = clamp8(by + sy);
            end
            m_ax = bx;
            m_ay = by;
            m_en = en;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk_sys) begin
        check("cmp_mouse_en", {31'd0, mouse_en}, {31'd0, m_en});
        check("cmp_port_out", {26'd0, port_out}, {26'd0, m_port});
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_report(input int x, input int y);
        mouse_x = 9'(x);
        mouse_y = 9'(y);
        mouse_strobe = 1'b1;
        cyc(1);
        mouse_strobe = 1'b0;
    endtask

    task automatic read_nib(output logic [3:0] n);
        stra = ~stra;
        cyc(1);
        n = port_out[3:0];
        cyc(50);
    endtask

    task automatic read4(output logic [15:0] w);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            read_nib(n);
            w = {w[11:0], n};
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] w;
        logic [3:0]  n;

        cyc(3);
        reset = 1'b0;
        check("reset_mouse_en", {31'd0, mouse_en}, 32'd0);
        check("reset_port_out", {26'd0, port_out}, 32'h3F);

        // Basic report and read.
        send_report(5, 3);
        check("enable_on_strobe", {31'd0, mouse_en}, 32'd1);
        read4(w);
        check("read_x5_y3", {16'd0, w}, 32'hFB03);

        // Saturation then clear.
        repeat (3) send_report(-100, 0);
        read4(w);
        check("read_saturated", {16'd0, w}, 32'h7F00);
        read4(w);
        check("read_cleared", {16'd0, w}, 32'h0000);

        // Timeout resync: third read after the gap is a new X-high.
        send_report(-'h30, 'h50);
        read_nib(n);
        check("to_xh", {28'd0, n}, 32'h3);
        read_nib(n);
        check("to_xl", {28'd0, n}, 32'h0);
        cyc(TO + 2);
        send_report(-'h70, 0);
        read_nib(n);
        check("to_resync_xh", {28'd0, n}, 32'h7);
        cyc(TO + 2);

        // Buttons, then joystick takes the port.
        mouse_flags = 8'h01;
        cyc(1);
        check("buttons", {30'd0, port_out[5:4]}, 32'h2);
        joy_active = 1'b1;
        cyc(1);
        check("joy_mouse_en", {31'd0, mouse_en}, 32'd0);
        check("joy_port_out", {26'd0, port_out}, 32'h3F);
        joy_active = 1'b0;
        mouse_flags = 8'h00;
        cyc(3);

        // Report coinciding with the XH toggle.
        send_report(-10, 0);
        stra = ~stra;
        mouse_x = 9'(-2);
        mouse_y = 9'd0;
        mouse_strobe = 1'b1;
        cyc(1);
        mouse_strobe = 1'b0;
        n = port_out[3:0];
        check("coinc_xh", {28'd0, n}, 32'h0);
        cyc(50);
        read_nib(n);
        check("coinc_xl", {28'd0, n}, 32'hA);
        read_nib(n);
        read_nib(n);
        read4(w);
        check("coinc_next", {16'd0, w}, 32'h0200);

        // Asynchronous reset mid-sequence (at YH).
        send_report(-'h12, 'h34);
        read_nib(n);
        read_nib(n);
        cyc(5);
        #2 reset = 1'b1;
        #1;
        check("async_mouse_en", {31'd0, mouse_en}, 32'd0);
        check("async_port_out", {26'd0, port_out}, 32'h3F);
        cyc(2);
        reset = 1'b0;
        stra = 1'b0;
        cyc(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            mouse_strobe = ($urandom_range(0, 19) == 0);
            mouse_x = 9'($urandom);
            mouse_y = 9'($urandom);
            if ($urandom_range(0, 7) == 0) mouse_x = 9'h100;
            if ($urandom_range(0, 7) == 0) mouse_y = 9'h0FF;
            mouse_flags = 8'($urandom);
            joy_active = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) stra = ~stra;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                cyc(1);
                reset = 1'b0;
                stra = 1'b0;
            end
            cyc(1);
            if ($urandom_range(0, 299) == 0) begin
                mouse_strobe = 1'b0;
                joy_active = 1'b0;
                cyc(TO + $urandom_range(0, 20));
            end
        end
        mouse_strobe = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
